uart_rx_word_assembler: RTL and testbench

UART_RX_WORD_ASSEMBLER -- requirements
Module: uart_rx_word_assembler

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_rx_word_assembler.sv | 105 ++++++++++
 tb/tb_uart_rx_word_assembler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: word-assembly states and byte-lane layout.
// Bytes are packed little-endian; the first byte received lands in the low lane.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int PART_W = 3 * BYTE_W;

  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 8;
  localparam int LANE2_LSB = 16;
  localparam int LANE3_LSB = 24;

  // State value equals the number of bytes already held in the partial word.
  typedef enum logic [1:0] {
    ASM_B0 = 2'd0,
    ASM_B1 = 2'd1,
    ASM_B2 = 2'd2,
    ASM_B3 = 2'd3
  } asm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push is visible on head the next cycle.
// Pop on empty is ignored; push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop_ok;
  logic             push_ok;

  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign pop_ok    = pop && not_empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs UART bytes little-endian into 32-bit words and buffers them in a FWFT FIFO (word visible 1 cycle after 4th byte).
// Words arriving while full with no pop are dropped and flagged sticky in overrun_o; stale partial words time out.
module uart_rx_word_assembler
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] rx_byte_i,
  input  logic              rx_valid_i,
  input  logic              rd_en_i,
  input  logic              clr_overrun_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic              full_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  asm_state_t        state;
  logic [PART_W-1:0] partial;
  logic [CNT_W-1:0]  idle_cnt;
  logic              push;
  logic [WORD_W-1:0] push_data;

  assign push = rx_valid_i && (state == ASM_B3);

  always_comb begin
    push_data = WORD_W'(partial);
    push_data[LANE3_LSB +: BYTE_W] = rx_byte_i;
  end

  // A byte arriving on the would-be timeout cycle wins: it is taken and the counter restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASM_B0;
      partial   <= '0;
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (rx_valid_i) begin
        idle_cnt <= '0;
        unique case (state)
          ASM_B0: begin
            partial[LANE0_LSB +: BYTE_W] <= rx_byte_i;
            state <= ASM_B1;
          end
          ASM_B1: begin
            partial[LANE1_LSB +: BYTE_W] <= rx_byte_i;
            state <= ASM_B2;
          end
          ASM_B2: begin
            partial[LANE2_LSB +: BYTE_W] <= rx_byte_i;
            state <= ASM_B3;
          end
          ASM_B3: begin
            partial <= '0;
            state   <= ASM_B0;
          end
        endcase
      end else if (state != ASM_B0) begin
        if (idle_cnt == CNT_LAST) begin
          state     <= ASM_B0;
          partial   <= '0;
          idle_cnt  <= '0;
          timeout_o <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + CNT_W'(1);
        end
      end
    end
  end

  // A fresh drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_o <= 1'b0;
    end else if (push && full_o && !rd_en_i) begin
      overrun_o <= 1'b1;
    end else if (clr_overrun_i) begin
      overrun_o <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en_i),
    .head      (word_o),
    .not_empty (word_valid_o),
    .full      (full_o)
  );

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed bench: a queue-based reference model is compared every cycle, plus hand-computed literal checks.
module tb_uart_rx_word_assembler;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic        clr_overrun_i = 1'b0;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        full_o;
  logic        overrun_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] mq[$];
  logic [7:0]  mpart[$];
  int          midle = 0;
  bit          movr = 1'b0;
  bit          mto = 1'b0;

  uart_rx_word_assembler #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_byte_i     (rx_byte_i),
    .rx_valid_i    (rx_valid_i),
    .rd_en_i       (rd_en_i),
    .clr_overrun_i (clr_overrun_i),
    .word_o        (word_o),
    .word_valid_o  (word_valid_o),
    .full_o        (full_o),
    .overrun_o     (overrun_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: words are a queue, the partial word is a byte list, timeout is an idle-cycle count.
  task automatic model(input bit r, input bit v, input logic [7:0] b, input bit rd, input bit clr);
    logic [31:0] w;
    bit popped;
    bit pushed;
    bit dropped;
    w = '0;
    pushed = 1'b0;
    dropped = 1'b0;
    if (r) begin
      mq.delete();
      mpart.delete();
      midle = 0;
      movr = 1'b0;
      mto = 1'b0;
      return;
    end
    popped = rd && (mq.size() > 0);
    mto = 1'b0;
    if (v) begin
      mpart.push_back(b);
      midle = 0;
      if (mpart.size() == 4) begin
        w = {mpart[3], mpart[2], mpart[1], mpart[0]};
        mpart.delete();
        if (mq.size() < DEPTH || popped) pushed = 1'b1;
        else dropped = 1'b1;
      end
    end else if (mpart.size() > 0) begin
      midle++;
      if (midle == TMO) begin
        mpart.delete();
        midle = 0;
        mto = 1'b1;
      end
    end
    if (popped) void'(mq.pop_front());
    if (pushed) mq.push_back(w);
    if (dropped) movr = 1'b1;
    else if (clr) movr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("word_o", word_o, (mq.size() > 0) ? mq[0] : 32'h0);
      check("word_valid_o", {31'b0, word_valid_o}, 32'(mq.size() > 0));
      check("full_o", {31'b0, full_o}, 32'(mq.size() == DEPTH));
      check("overrun_o", {31'b0, overrun_o}, {31'b0, movr});
      check("timeout_o", {31'b0, timeout_o}, {31'b0, mto});
    end
  end

  task automatic step(input bit r, input bit v, input logic [7:0] b, input bit rd, input bit clr);
    rst = r;
    rx_valid_i = v;
    rx_byte_i = b;
    rd_en_i = rd;
    clr_overrun_i = clr;
    @(posedge clk);
    model(r, v, b, rd, clr);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rd_last, input bit clr_last);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    step(1'b0, 1'b1, w[31:24], rd_last, clr_last);
  endtask

  initial begin
    logic [31:0] exp_words [4];

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst word_o", word_o, 32'h0);
    check("rst word_valid_o", {31'b0, word_valid_o}, 32'h0);
    check("rst full_o", {31'b0, full_o}, 32'h0);

    // Basic little-endian packing, with idle gaps shorter than the timeout.
    send(8'h11);
    send(8'h22);
    idle(3);
    send(8'h33);
    send(8'h44);
    check("basic word_o", word_o, 32'h44332211);
    check("basic word_valid_o", {31'b0, word_valid_o}, 32'h1);
    pop1();
    check("basic popped valid", {31'b0, word_valid_o}, 32'h0);

    // Five words with no reads; the last byte also carries a clear, which must lose.
    for (int n = 1; n <= 4; n++) begin
      send_word(32'h03020100 + 32'(n) * 32'h10101010, 1'b0, 1'b0);
    end
    check("fill full_o", {31'b0, full_o}, 32'h1);
    check("fill overrun_o", {31'b0, overrun_o}, 32'h0);
    send_word(32'h53525150, 1'b0, 1'b1);
    check("drop overrun_o", {31'b0, overrun_o}, 32'h1);
    check("drop full_o", {31'b0, full_o}, 32'h1);
    exp_words[0] = 32'h13121110;
    exp_words[1] = 32'h23222120;
    exp_words[2] = 32'h33323130;
    exp_words[3] = 32'h43424140;
    for (int i = 0; i < 4; i++) begin
      check("readback word_o", word_o, exp_words[i]);
      pop1();
    end
    check("drained word_o", word_o, 32'h0);
    pop1();
    check("underflow valid", {31'b0, word_valid_o}, 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr overrun_o", {31'b0, overrun_o}, 32'h0);

    // Two bytes then a full timeout window.
    send(8'h5A);
    send(8'h5B);
    idle(TMO - 1);
    check("pre-timeout", {31'b0, timeout_o}, 32'h0);
    idle(1);
    check("timeout pulse", {31'b0, timeout_o}, 32'h1);
    idle(1);
    check("timeout one cycle", {31'b0, timeout_o}, 32'h0);
    send_word(32'hA3A2A1A0, 1'b0, 1'b0);
    check("post-timeout word_o", word_o, 32'hA3A2A1A0);
    pop1();

    // Byte on the exact timeout cycle is accepted instead.
    send(8'hB0);
    idle(TMO - 1);
    send(8'hB1);
    check("race no timeout", {31'b0, timeout_o}, 32'h0);
    send(8'hB2);
    send(8'hB3);
    check("race word_o", word_o, 32'hB3B2B1B0);
    pop1();

    // Full FIFO, completing byte coincides with a pop.
    for (int n = 6; n <= 9; n++) begin
      send_word(32'h03020100 + 32'(n) * 32'h10101010, 1'b0, 1'b0);
    end
    send_word(32'hF3F2F1F0, 1'b1, 1'b0);
    check("pop-push full_o", {31'b0, full_o}, 32'h1);
    check("pop-push overrun_o", {31'b0, overrun_o}, 32'h0);
    check("pop-push head", word_o, 32'h73727170);

    // Reset mid-word with two words buffered; all other inputs active.
    pop1();
    pop1();
    check("two left head", word_o, 32'h93929190);
    send(8'hD0);
    send(8'hD1);
    send(8'hD2);
    step(1'b1, 1'b1, 8'hD3, 1'b1, 1'b1);
    check("mid rst word_o", word_o, 32'h0);
    check("mid rst valid", {31'b0, word_valid_o}, 32'h0);
    check("mid rst full", {31'b0, full_o}, 32'h0);
    pop1();
    check("rst empty pop", {31'b0, word_valid_o}, 32'h0);
    send_word(32'hC3C2C1C0, 1'b0, 1'b0);
    check("after rst word_o", word_o, 32'hC3C2C1C0);

    // Simultaneous push and pop on a partly filled FIFO.
    send_word(32'hE3E2E1E0, 1'b1, 1'b0);
    check("swap word_o", word_o, 32'hE3E2E1E0);
    check("swap full_o", {31'b0, full_o}, 32'h0);
    pop1();
    check("swap drained", {31'b0, word_valid_o}, 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
